dccm_bank_array: RTL

Banked DCCM storage that answers the LSU DCCM port: one write port and one dual-address read port, both driven by the LSU DCCM controller. Stores data plus ECC (FDATA) per 32-bit word across `NUM_BANKS` single-ported banks. Returns read data one cycle after the request. After reset it runs a sweep that writes zero to every row before accepting traffic. Sits between `lsu_dccm_ctl` and the physical DCCM SRAM macros.

---
 rtl/dccm_bank_array_pkg.sv | 14 +
 rtl/dccm_bank_array_sram.sv | 27 ++
 rtl/dccm_bank_array.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/dccm_bank_array_pkg.sv
// Shared DCCM types: post-reset sweep state and the default bank/row split.
package swerv_types;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } dccm_init_state_t;

  localparam int DCCM_BITS_DFLT = 16;
  localparam int NUM_BANKS_DFLT = 8;
  localparam int DCCM_BANK_BITS = $clog2(NUM_BANKS_DFLT);
  localparam int DCCM_ROW_BITS  = DCCM_BITS_DFLT - 2 - DCCM_BANK_BITS;

endpackage

// File: rtl/dccm_bank_array_sram.sv
// One single-ported DCCM bank; a technology macro drops in here.
module dccm_bank_sram #(
  parameter int ROW_BITS = 11,
  parameter int WIDTH    = 39
) (
  input  logic                clk,
  input  logic                rst_l,
  input  logic                en,
  input  logic                we,
  input  logic [ROW_BITS-1:0] addr,
  input  logic [WIDTH-1:0]    wdata,
  output logic [WIDTH-1:0]    rdata
);

  logic [WIDTH-1:0] mem [2**ROW_BITS];

  always_ff @(posedge clk) begin
    if (en && we) mem[addr] <= wdata;
  end

  // Output latch only moves on a read so the array outputs hold between reads.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l)         rdata <= '0;
    else if (en && !we) rdata <= mem[addr];
  end

endmodule

// File: rtl/dccm_bank_array.sv
// Banked DCCM: one write port, dual-address read port, zeroing sweep after reset.
module dccm_bank_array
  import swerv_types::*;
#(
  parameter int DCCM_BITS   = 16,
  parameter int NUM_BANKS   = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int FDATA_WIDTH = 39
) (
  input  logic                   clk,
  input  logic                   rst_l,
  input  logic                   dccm_wren,
  input  logic [DCCM_BITS-1:0]   dccm_wr_addr,
  input  logic [FDATA_WIDTH-1:0] dccm_wr_data,
  input  logic                   dccm_rden,
  input  logic [DCCM_BITS-1:0]   dccm_rd_addr_lo,
  input  logic [DCCM_BITS-1:0]   dccm_rd_addr_hi,
  output logic [FDATA_WIDTH-1:0] dccm_rd_data_lo,
  output logic [FDATA_WIDTH-1:0] dccm_rd_data_hi,
  output logic                   dccm_init_done,
  output logic                   dccm_conflict_err,
  output logic                   dccm_access_err
);

  localparam int BANK_BITS = $clog2(NUM_BANKS);
  localparam int ROW_BITS  = DCCM_BITS - 2 - BANK_BITS;
  localparam int ECC_BITS  = FDATA_WIDTH - DATA_WIDTH;

  logic [BANK_BITS-1:0] wr_bank, lo_bank, hi_bank;
  logic [ROW_BITS-1:0]  wr_row, lo_row, hi_row;

  assign wr_bank = dccm_wr_addr[2 +: BANK_BITS];
  assign lo_bank = dccm_rd_addr_lo[2 +: BANK_BITS];
  assign hi_bank = dccm_rd_addr_hi[2 +: BANK_BITS];
  assign wr_row  = dccm_wr_addr[DCCM_BITS-1 : 2+BANK_BITS];
  assign lo_row  = dccm_rd_addr_lo[DCCM_BITS-1 : 2+BANK_BITS];
  assign hi_row  = dccm_rd_addr_hi[DCCM_BITS-1 : 2+BANK_BITS];

  dccm_init_state_t    state_q, state_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic                sweep;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= INIT;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    sweep   = 1'b0;
    case (state_q)
      INIT: begin
        sweep = 1'b1;
        row_d = row_q + 1'b1;
        if (row_q == '1) begin
          state_d = READY;
          row_d   = '0;
        end
      end
      READY: ;
      default: state_d = INIT;
    endcase
  end

  logic rd_go, wr_req, conflict, wr_go;

  assign rd_go    = (state_q == READY) && dccm_rden;
  assign wr_req   = (state_q == READY) && dccm_wren;
  // Read wins a bank collision; the write is silently dropped and flagged.
  assign conflict = rd_go && wr_req && ((wr_bank == lo_bank) || (wr_bank == hi_bank));
  assign wr_go    = wr_req && !conflict;

  logic [NUM_BANKS-1:0][FDATA_WIDTH-1:0] bank_rdata;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic                   en, we, rd_lo, rd_hi;
    logic [ROW_BITS-1:0]    addr;
    logic [FDATA_WIDTH-1:0] wdata;

    assign rd_lo = rd_go && (lo_bank == BANK_BITS'(b));
    assign rd_hi = rd_go && (hi_bank == BANK_BITS'(b));

    always_comb begin
      en    = 1'b0;
      we    = 1'b0;
      addr  = wr_row;
      wdata = dccm_wr_data;
      if (sweep) begin
        en    = 1'b1;
        we    = 1'b1;
        addr  = row_q;
        wdata = {{ECC_BITS{1'b0}}, {DATA_WIDTH{1'b0}}};
      end else if (rd_lo) begin
        en   = 1'b1;
        addr = lo_row;
      end else if (rd_hi) begin
        en   = 1'b1;
        addr = hi_row;
      end else if (wr_go && (wr_bank == BANK_BITS'(b))) begin
        en = 1'b1;
        we = 1'b1;
      end
    end

    dccm_bank_sram #(
      .ROW_BITS (ROW_BITS),
      .WIDTH    (FDATA_WIDTH)
    ) u_sram (
      .clk   (clk),
      .rst_l (rst_l),
      .en    (en),
      .we    (we),
      .addr  (addr),
      .wdata (wdata),
      .rdata (bank_rdata[b])
    );
  end

  logic [BANK_BITS-1:0] lo_bank_q, hi_bank_q;
  logic                 conflict_q, access_q;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      lo_bank_q  <= '0;
      hi_bank_q  <= '0;
      conflict_q <= 1'b0;
      access_q   <= 1'b0;
    end else begin
      if (rd_go) begin
        lo_bank_q <= lo_bank;
        hi_bank_q <= hi_bank;
      end
      conflict_q <= conflict;
      access_q   <= (state_q == INIT) && (dccm_wren || dccm_rden);
    end
  end

  assign dccm_rd_data_lo   = bank_rdata[lo_bank_q];
  assign dccm_rd_data_hi   = bank_rdata[hi_bank_q];
  assign dccm_init_done    = (state_q == READY);
  assign dccm_conflict_err = conflict_q;
  assign dccm_access_err   = access_q;

endmodule
